// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter: shares one MIG user port between a frame writer
// (write FIFO -> DDR3) and a frame reader (DDR3 -> read FIFO).
// Bursts of BURST_LEN 256-bit words are granted round-robin when both
// sides are eligible. Each side walks a circular frame of FRAME_LEN words.
//
// Handshake: a command is accepted in any cycle where app_en and app_rdy are
// both high. A write beat additionally needs app_wdf_rdy, because the command
// and its data are presented together. wfifo_rden is high exactly on an
// accepted write beat. Returning read data is never stalled, so
// app_rd_data_valid is passed straight through to rfifo_wren.
module ddr3_rw_arbiter #(
    parameter int          BURST_LEN = 64,
    parameter int          FRAME_LEN = 24576,
    parameter logic [27:0] WR_BASE   = 28'h0000000,
    parameter logic [27:0] RD_BASE   = 28'h0000000,
    parameter int          RD_SPACE  = 1024
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        init_calib_complete,
    input  logic        wr_load,
    input  logic        rd_load,
    input  logic [10:0] wfifo_rcount,
    input  logic [10:0] rfifo_wcount,
    input  logic        app_rdy,
    input  logic        app_wdf_rdy,
    input  logic        app_rd_data_valid,
    output logic        app_en,
    output logic        app_wdf_wren,
    output logic        app_wdf_end,
    output logic [2:0]  app_cmd,
    output logic [27:0] app_addr,
    output logic        wfifo_rden,
    output logic        rfifo_wren,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam int PTR_W  = $clog2(FRAME_LEN);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        CALIB = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [10:0]        outstanding;
    logic               wr_load_d0;
    logic               rd_load_d0;
    logic               wr_pend;
    logic               rd_pend;
    logic               rd_seen;
    logic               last_grant;   // 0 = write, 1 = read
    logic               grant_wr;
    logic               grant_rd;
    logic               wr_accept;
    logic               rd_accept;
    logic               burst_last;
    logic               wr_elig;
    logic               rd_elig;
    logic [11:0]        rd_sum;
    logic               wr_edge;
    logic               rd_edge;

    assign wr_accept  = (state == WRITE) && app_rdy && app_wdf_rdy && !rst;
    assign rd_accept  = (state == READ) && app_rdy && !rst;
    assign burst_last = (beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign wr_edge    = wr_load && !wr_load_d0;
    assign rd_edge    = rd_load && !rd_load_d0;
    assign rd_sum     = {1'b0, rfifo_wcount} + {1'b0, outstanding};
    assign wr_elig    = (wfifo_rcount >= 11'(BURST_LEN));
    assign rd_elig    = rd_seen && (rd_sum < 12'(RD_SPACE));

    // Next-state and grant decision; a burst always runs to its end.
    always_comb begin
        state_nxt = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        unique case (state)
            CALIB: begin
                if (init_calib_complete) state_nxt = IDLE;
            end
            IDLE: begin
                if (!init_calib_complete) begin
                    state_nxt = CALIB;
                end else if (wr_elig && (!rd_elig || last_grant)) begin
                    grant_wr  = 1'b1;
                    state_nxt = WRITE;
                end else if (rd_elig) begin
                    grant_rd  = 1'b1;
                    state_nxt = READ;
                end
            end
            WRITE: begin
                if (wr_accept && burst_last)
                    state_nxt = init_calib_complete ? IDLE : CALIB;
            end
            READ: begin
                if (rd_accept && burst_last)
                    state_nxt = init_calib_complete ? IDLE : CALIB;
            end
        endcase
    end

    // MIG-facing outputs, decoded from state and forced low during reset.
    always_comb begin
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        app_cmd      = 3'b000;
        app_addr     = 28'h0;
        busy         = 1'b0;
        if (!rst) begin
            if (state == WRITE) begin
                app_en       = 1'b1;
                app_wdf_wren = 1'b1;
                app_wdf_end  = 1'b1;
                app_cmd      = 3'b000;
                app_addr     = WR_BASE + (28'(wr_ptr) << 3);
                busy         = 1'b1;
            end else if (state == READ) begin
                app_en   = 1'b1;
                app_cmd  = 3'b001;
                app_addr = RD_BASE + (28'(rd_ptr) << 3);
                busy     = 1'b1;
            end
        end
    end

    assign wfifo_rden = wr_accept;
    assign rfifo_wren = app_rd_data_valid && !rst;
    assign state_dbg  = rst ? 2'd0 : state;

    // State register, beat counter and grant history.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            state      <= CALIB;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (wr_accept || rd_accept)
                beat_cnt <= burst_last ? '0 : beat_cnt + 1'b1;
            if (grant_wr)
                last_grant <= 1'b0;
            else if (grant_rd)
                last_grant <= 1'b1;
        end
    end

    // Load-edge detection; restarts are held pending until the next IDLE.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            wr_load_d0 <= 1'b0;
            rd_load_d0 <= 1'b0;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            rd_seen    <= 1'b0;
        end else begin
            wr_load_d0 <= wr_load;
            rd_load_d0 <= rd_load;
            wr_pend    <= wr_edge || (wr_pend && (state != IDLE));
            rd_pend    <= rd_edge || (rd_pend && (state != IDLE));
            rd_seen    <= rd_seen || rd_edge;
        end
    end

    // Frame pointers: cleared by a pending restart in IDLE, else step per accept.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (state == IDLE && wr_pend)
                wr_ptr <= '0;
            else if (wr_accept)
                wr_ptr <= (wr_ptr == PTR_W'(FRAME_LEN - 1)) ? '0 : wr_ptr + 1'b1;
            if (state == IDLE && rd_pend)
                rd_ptr <= '0;
            else if (rd_accept)
                rd_ptr <= (rd_ptr == PTR_W'(FRAME_LEN - 1)) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Reads issued but not yet returned; saturates at zero on stray data.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            unique case ({rd_accept, app_rd_data_valid})
                2'b10:   outstanding <= outstanding + 11'd1;
                2'b01:   if (outstanding != 11'd0) outstanding <= outstanding - 11'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule
